// File: rtl/act_lut_loader.sv
// Streaming loader for the activation coefficient LUT: decodes a header word,
// then turns each accepted coefficient word into one registered LUT write.
module act_lut_loader #(
    parameter int ACT_LUT_DEPTH = 5,
    parameter int ACT_MASK_SIZE = 2,
    parameter int ACT_LUT_SIZE  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ACT_LUT_SIZE-1:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     abort,
    output logic                     write_enable,
    output logic [ACT_MASK_SIZE-1:0] write_mask,
    output logic [ACT_LUT_DEPTH-1:0] write_addr,
    output logic [ACT_LUT_SIZE-1:0]  write_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int ENTRIES = 1 << ACT_LUT_DEPTH;
    localparam logic [ACT_LUT_DEPTH:0] LAST_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: a word moves on any cycle where in_valid && in_ready.
    // in_ready drops in DONE, under abort, and while reset is asserted.
    state_t                   state;
    logic [ACT_MASK_SIZE-1:0] mask_r;
    logic [ACT_LUT_DEPTH-1:0] addr_r;
    logic [ACT_LUT_DEPTH:0]   remaining;

    logic [15:0]              hdr_count;
    logic [ACT_MASK_SIZE-1:0] hdr_mask;
    logic [ACT_LUT_DEPTH-1:0] hdr_addr;
    logic                     xfer;

    assign hdr_count = in_data[ACT_LUT_SIZE-1 -: 16];
    assign hdr_mask  = in_data[ACT_LUT_DEPTH +: ACT_MASK_SIZE];
    assign hdr_addr  = in_data[ACT_LUT_DEPTH-1:0];
    assign in_ready  = rst_n && !abort && (state != S_DONE);
    assign xfer      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            mask_r       <= '0;
            addr_r       <= '0;
            remaining    <= '0;
            write_enable <= 1'b0;
            write_mask   <= '0;
            write_addr   <= '0;
            write_data   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            if (abort) begin
                // Entries already written stay written; the load just ends.
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (xfer && hdr_count != 16'd0) begin
                            if ({16'd0, hdr_count} > 32'(ENTRIES)) begin
                                err <= 1'b1;
                            end else begin
                                mask_r    <= hdr_mask;
                                addr_r    <= hdr_addr;
                                remaining <= hdr_count[ACT_LUT_DEPTH:0];
                                state     <= S_LOAD;
                                busy      <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (xfer) begin
                            write_enable <= 1'b1;
                            write_mask   <= mask_r;
                            write_addr   <= addr_r;
                            write_data   <= in_data;
                            addr_r       <= addr_r + 1'b1;
                            remaining    <= remaining - 1'b1;
                            if (remaining == LAST_ONE) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_act_lut_loader.sv
// Scoreboard bench for act_lut_loader: directed loads push expected writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_act_lut_loader;

    localparam int W = 2 + 5 + 32;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        abort;
    logic        write_enable;
    logic [1:0]  write_mask;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int busy_cnt = 0;

    logic [W-1:0] exp_q[$];

    act_lut_loader dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .abort(abort), .write_enable(write_enable),
        .write_mask(write_mask), .write_addr(write_addr), .write_data(write_data),
        .busy(busy), .done(done), .err(err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (write_enable) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h expected none",
                         {write_mask, write_addr, write_data});
            end else begin
                check("write", 64'({write_mask, write_addr, write_data}), 64'(exp_q.pop_front()));
            end
        end
        if (done) begin
            done_cnt++;
            check("done_with_write", 64'(write_enable), 64'd1);
        end
        if (err) err_cnt++;
        if (busy) busy_cnt++;
    end

    // drivers
    function automatic logic [31:0] hdr(input int cnt, input int mask, input int addr);
        logic [15:0] c;
        logic [1:0]  m;
        logic [4:0]  a;
        c = 16'(cnt);
        m = 2'(mask);
        a = 5'(addr);
        return {c, 9'd0, m, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_data(input int mask, input int addr, input logic [31:0] d);
        exp_q.push_back({2'(mask), 5'(addr), d});
        send_word(d);
    endtask

    int we0, dn0, er0, bc0;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = hdr(3, 2, 0);
        abort    = 1'b0;

        // reset holds everything low even with valid asserted
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_outputs", 64'({write_enable, write_mask, write_addr, busy, done, err}), 64'd0);
        check("rst_write_data", 64'(write_data), 64'd0);
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        step();
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);
        step();

        // basic load: mask 2, addr 0, three back-to-back words
        we0 = we_cnt; dn0 = done_cnt; bc0 = busy_cnt;
        send_word(hdr(3, 2, 0));
        send_data(2, 0, 32'h11111111);
        send_data(2, 1, 32'h22222222);
        send_data(2, 2, 32'h33333333);
        @(negedge clk);
        check("basic_done_ready", 64'(in_ready), 64'd0);
        check("basic_done", 64'(done), 64'd1);
        check("basic_done_busy", 64'(busy), 64'd1);
        step();
        @(negedge clk);
        check("basic_idle_ready", 64'(in_ready), 64'd1);
        check("basic_idle_busy", 64'(busy), 64'd0);
        check("basic_busy_cycles", 64'(busy_cnt - bc0), 64'd4);
        check("basic_writes", 64'(we_cnt - we0), 64'd3);
        check("basic_done_count", 64'(done_cnt - dn0), 64'd1);
        step();

        // wrap and stall: mask 1 from addr 30
        we0 = we_cnt; dn0 = done_cnt;
        send_word(hdr(4, 1, 30));
        send_data(1, 30, 32'hCAFE0001);
        send_data(1, 31, 32'hCAFE0002);
        repeat (3) step();
        check("stall_writes", 64'(we_cnt - we0), 64'd2);
        check("stall_busy", 64'(busy), 64'd1);
        send_data(1, 0, 32'hCAFE0003);
        send_data(1, 1, 32'hCAFE0004);
        repeat (2) step();
        check("wrap_writes", 64'(we_cnt - we0), 64'd4);
        check("wrap_done_count", 64'(done_cnt - dn0), 64'd1);

        // reject, no-op, then a full table
        we0 = we_cnt; dn0 = done_cnt; er0 = err_cnt;
        send_word(hdr(33, 0, 0));
        @(negedge clk);
        check("reject_err", 64'(err), 64'd1);
        check("reject_busy", 64'(busy), 64'd0);
        check("reject_ready", 64'(in_ready), 64'd1);
        step();
        send_word(hdr(0, 3, 3));
        repeat (2) step();
        check("noop_busy", 64'(busy), 64'd0);
        check("reject_noop_err_count", 64'(err_cnt - er0), 64'd1);
        check("reject_noop_writes", 64'(we_cnt - we0), 64'd0);
        check("reject_noop_done", 64'(done_cnt - dn0), 64'd0);
        send_word(hdr(32, 3, 0));
        for (int i = 0; i < 32; i++) send_data(3, i, 32'hA5000000 + 32'(i));
        repeat (2) step();
        check("full_writes", 64'(we_cnt - we0), 64'd32);
        check("full_done_count", 64'(done_cnt - dn0), 64'd1);

        // abort after two data words of a five-word load
        we0 = we_cnt; dn0 = done_cnt;
        send_word(hdr(5, 2, 10));
        send_data(2, 10, 32'hBEEF0001);
        send_data(2, 11, 32'hBEEF0002);
        in_data  = hdr(1, 1, 5);
        in_valid = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        check("abort_ready", 64'(in_ready), 64'd0);
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_writes", 64'(we_cnt - we0), 64'd2);
        check("abort_no_done", 64'(done_cnt - dn0), 64'd0);
        step();
        send_word(hdr(1, 1, 5));
        send_data(1, 5, 32'h0000D00D);
        repeat (2) step();
        check("post_abort_writes", 64'(we_cnt - we0), 64'd3);
        check("post_abort_done", 64'(done_cnt - dn0), 64'd1);

        // reset mid-load: the pending write is dropped, so nothing is queued
        we0 = we_cnt;
        send_word(hdr(4, 0, 0));
        send_word(32'h77777777);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", 64'({write_enable, write_mask, write_addr, busy, done, err}), 64'd0);
        check("midrst_data", 64'(write_data), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        check("midrst_writes", 64'(we_cnt - we0), 64'd0);
        send_word(hdr(2, 2, 7));
        send_data(2, 7, 32'h12345678);
        send_data(2, 8, 32'h9ABCDEF0);
        repeat (2) step();
        check("midrst_reload_writes", 64'(we_cnt - we0), 64'd2);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
